// File: rtl/ksa16_sub_pipe_pkg.sv
// Shared constants and stage-boundary structs for the pipelined 16-bit Kogge-Stone subtractor.
package ksa16_sub_pipe_pkg;

  localparam int KSA_WIDTH  = 16;
  localparam int KSA_LEVELS = 4;

  // Prefix levels evaluated in each pipeline stage (level n has span 2**n).
  localparam int S2_FIRST_LVL = 0;
  localparam int S2_LAST_LVL  = 1;
  localparam int S3_FIRST_LVL = 2;
  localparam int S3_LAST_LVL  = KSA_LEVELS - 1;

  // S1 -> S2: per-bit generate/propagate, carry-in already folded into g[0].
  typedef struct packed {
    logic [KSA_WIDTH-1:0] g;
    logic [KSA_WIDTH-1:0] p;
    logic                 a_msb;
    logic                 b_msb;
  } s1_t;

  // S2 -> S3: group G/P after the first two levels, plus raw p for the sum.
  typedef struct packed {
    logic [KSA_WIDTH-1:0] gg;
    logic [KSA_WIDTH-1:0] pp;
    logic [KSA_WIDTH-1:0] p;
    logic                 a_msb;
    logic                 b_msb;
  } s2_t;

endpackage

// File: rtl/ksa_black_cell.sv
// Kogge-Stone black cell: merges group (i) with the lower group (j).
module ksa_black_cell (
  input  logic gi_i,
  input  logic pi_i,
  input  logic gj_i,
  input  logic pj_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gi_i | (pi_i & gj_i);
  assign p_o = pi_i & pj_i;

endmodule

// File: rtl/ksa16_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: diff = a + ~b + 1, with borrow/ovf/zero flags.
// A single global stall (advance) moves all stages together; bubbles are not collapsed.
module ksa16_sub_pipe
  import ksa16_sub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  if (int'(WIDTH) != KSA_WIDTH) begin : g_width_check
    $error("ksa16_sub_pipe supports WIDTH=16 only");
  end

  localparam int NumS2 = S2_LAST_LVL - S2_FIRST_LVL + 1;
  localparam int NumS3 = S3_LAST_LVL - S3_FIRST_LVL + 1;

  logic advance;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  logic [KSA_WIDTH-1:0] diff_d, diff_q;
  logic                 borrow_d, borrow_q;
  logic                 ovf_d, ovf_q;
  logic                 zero_d, zero_q;

  logic [NumS2:0][KSA_WIDTH-1:0] s2_g_lvl, s2_p_lvl;
  logic [NumS3:0][KSA_WIDTH-1:0] s3_g_lvl, s3_p_lvl;
  logic [KSA_WIDTH-1:0]          carry;
  logic                          unused_final_p;

  assign advance   = out_ready | ~v3_q;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Valid bits shift together on advance and hold on stall.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (advance) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
    end
  end

  // S1: per-bit generate/propagate against ~b; carry-in of 1 merged into bit 0.
  always_comb begin
    s1_d.g     = a & ~b;
    s1_d.p     = a ^ ~b;
    s1_d.g[0]  = s1_d.g[0] | s1_d.p[0];
    s1_d.a_msb = a[WIDTH-1];
    s1_d.b_msb = b[WIDTH-1];
  end

  assign s2_g_lvl[0] = s1_q.g;
  assign s2_p_lvl[0] = s1_q.p;

  // S2 prefix levels; bits below the span pass straight through.
  for (genvar lv = S2_FIRST_LVL; lv <= S2_LAST_LVL; lv++) begin : g_s2_lvl
    localparam int Idx  = lv - S2_FIRST_LVL;
    localparam int Dist = 1 << lv;
    for (genvar i = 0; i < KSA_WIDTH; i++) begin : g_bit
      if (i >= Dist) begin : g_cell
        ksa_black_cell u_cell (
          .gi_i (s2_g_lvl[Idx][i]),
          .pi_i (s2_p_lvl[Idx][i]),
          .gj_i (s2_g_lvl[Idx][i-Dist]),
          .pj_i (s2_p_lvl[Idx][i-Dist]),
          .g_o  (s2_g_lvl[Idx+1][i]),
          .p_o  (s2_p_lvl[Idx+1][i])
        );
      end else begin : g_pass
        assign s2_g_lvl[Idx+1][i] = s2_g_lvl[Idx][i];
        assign s2_p_lvl[Idx+1][i] = s2_p_lvl[Idx][i];
      end
    end
  end

  // S2 register payload: partial group terms plus operand data still needed downstream.
  always_comb begin
    s2_d.gg    = s2_g_lvl[NumS2];
    s2_d.pp    = s2_p_lvl[NumS2];
    s2_d.p     = s1_q.p;
    s2_d.a_msb = s1_q.a_msb;
    s2_d.b_msb = s1_q.b_msb;
  end

  assign s3_g_lvl[0] = s2_q.gg;
  assign s3_p_lvl[0] = s2_q.pp;

  // S3 prefix levels complete the carry tree.
  for (genvar lv = S3_FIRST_LVL; lv <= S3_LAST_LVL; lv++) begin : g_s3_lvl
    localparam int Idx  = lv - S3_FIRST_LVL;
    localparam int Dist = 1 << lv;
    for (genvar i = 0; i < KSA_WIDTH; i++) begin : g_bit
      if (i >= Dist) begin : g_cell
        ksa_black_cell u_cell (
          .gi_i (s3_g_lvl[Idx][i]),
          .pi_i (s3_p_lvl[Idx][i]),
          .gj_i (s3_g_lvl[Idx][i-Dist]),
          .pj_i (s3_p_lvl[Idx][i-Dist]),
          .g_o  (s3_g_lvl[Idx+1][i]),
          .p_o  (s3_p_lvl[Idx+1][i])
        );
      end else begin : g_pass
        assign s3_g_lvl[Idx+1][i] = s3_g_lvl[Idx][i];
        assign s3_p_lvl[Idx+1][i] = s3_p_lvl[Idx][i];
      end
    end
  end

  // carry[i] is the carry out of bit i including the folded-in carry-in.
  assign carry          = s3_g_lvl[NumS3];
  assign unused_final_p = ^s3_p_lvl[NumS3];

  // Result fields; a bubble loads zeros so idle outputs read 0.
  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (advance) begin
      if (v2_q) begin
        diff_d   = s2_q.p ^ {carry[KSA_WIDTH-2:0], 1'b1};
        borrow_d = ~carry[KSA_WIDTH-1];
        ovf_d    = (s2_q.a_msb != s2_q.b_msb) && (diff_d[KSA_WIDTH-1] != s2_q.a_msb);
        zero_d   = (diff_d == '0);
      end else begin
        diff_d   = '0;
        borrow_d = 1'b0;
        ovf_d    = 1'b0;
        zero_d   = 1'b0;
      end
    end
  end

  // Control and output registers, synchronously reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Internal datapath registers; contents are qualified by the valid bits.
  always_ff @(posedge wb_clk_i) begin
    if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule
